vending_machine: RTL and testbench



---
 rtl/vending_machine.sv | 134 +++++++++++++
 tb/tb_vending_machine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// vending_machine: five-item vending controller.
// A request (item selection + money) is captured in IDLE, resolved in EVAL,
// and its result is held in HOLD until the request inputs change. Holding a
// request steady therefore vends it only once.
//
// Handshake: there is no valid/ready pair. A request is "valid" whenever the
// selection is nonzero in IDLE. It is consumed on that edge. The block is
// "ready" for the next request only after {selection, money} differs from the
// captured request, which returns it to IDLE.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic       cold_drink_i,
  input  logic       dairymilk_i,
  input  logic       biscuits_i,
  input  logic       redbull_i,
  input  logic       chocolated_i,
  input  logic [8:0] money_i,
  output logic       cold_drink_o,
  output logic       dairymilk_o,
  output logic       biscuits_o,
  output logic       redbull_o,
  output logic       chocolate_o,
  output logic       insufficient_money_o,
  output logic       money_invalid_o,
  output logic [8:0] return_change_o
);

  // Fixed item prices
  localparam logic [8:0] PRICE_COLD_DRINK = 9'd25;
  localparam logic [8:0] PRICE_DAIRYMILK  = 9'd20;
  localparam logic [8:0] PRICE_BISCUITS   = 9'd10;
  localparam logic [8:0] PRICE_REDBULL    = 9'd50;
  localparam logic [8:0] PRICE_CHOCOLATE  = 9'd30;
  localparam logic [8:0] MONEY_MAX        = 9'd500;

  // State is kept in a named register so checkers can bind to it directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] sel;
  logic [4:0] cap_sel;
  logic [8:0] cap_money;
  logic [8:0] cap_total;
  logic [8:0] req_total;
  logic       money_bad;
  logic       req_changed;

  // Bit order: {cold drink, dairymilk, biscuits, redbull, chocolate}
  assign sel = {cold_drink_i, dairymilk_i, biscuits_i, redbull_i, chocolated_i};

  // Price total of the live selection. The maximum is 135, so 9 bits cannot overflow.
  always_comb begin
    req_total = 9'd0;
    if (sel[4]) req_total = req_total + PRICE_COLD_DRINK;
    if (sel[3]) req_total = req_total + PRICE_DAIRYMILK;
    if (sel[2]) req_total = req_total + PRICE_BISCUITS;
    if (sel[1]) req_total = req_total + PRICE_REDBULL;
    if (sel[0]) req_total = req_total + PRICE_CHOCOLATE;
  end

  // Captured-money validity and detection of a changed request while held
  always_comb begin
    money_bad   = (cap_money == 9'd0) || ((cap_money % 9'd5) != 9'd0) ||
                  (cap_money > MONEY_MAX);
    req_changed = ({sel, money_i} != {cap_sel, cap_money});
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      cap_sel              <= 5'd0;
      cap_money            <= 9'd0;
      cap_total            <= 9'd0;
      cold_drink_o         <= 1'b0;
      dairymilk_o          <= 1'b0;
      biscuits_o           <= 1'b0;
      redbull_o            <= 1'b0;
      chocolate_o          <= 1'b0;
      insufficient_money_o <= 1'b0;
      money_invalid_o      <= 1'b0;
      return_change_o      <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sel != 5'd0) begin
            cap_sel   <= sel;
            cap_money <= money_i;
            cap_total <= req_total;
            state     <= EVAL;
          end
        end
        EVAL: begin
          // Priority: invalid money, then insufficient money, then vend.
          if (money_bad) begin
            money_invalid_o <= 1'b1;
            return_change_o <= cap_money;
          end else if (cap_money < cap_total) begin
            insufficient_money_o <= 1'b1;
            return_change_o      <= cap_money;
          end else begin
            cold_drink_o    <= cap_sel[4];
            dairymilk_o     <= cap_sel[3];
            biscuits_o      <= cap_sel[2];
            redbull_o       <= cap_sel[1];
            chocolate_o     <= cap_sel[0];
            return_change_o <= cap_money - cap_total;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (req_changed) begin
            cold_drink_o         <= 1'b0;
            dairymilk_o          <= 1'b0;
            biscuits_o           <= 1'b0;
            redbull_o            <= 1'b0;
            chocolate_o          <= 1'b0;
            insufficient_money_o <= 1'b0;
            money_invalid_o      <= 1'b0;
            return_change_o      <= 9'd0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Testbench for vending_machine: directed steps followed by randomized requests,
// all checked against a price-table reference model.
module tb_vending_machine;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sel = 5'd0;
  logic [8:0] money = 9'd0;

  logic       cold_drink_o, dairymilk_o, biscuits_o, redbull_o, chocolate_o;
  logic       insufficient_money_o, money_invalid_o;
  logic [8:0] return_change_o;

  always #5 clk = ~clk;

  vending_machine dut (
    .clk                  (clk),
    .rst                  (rst),
    .cold_drink_i         (sel[4]),
    .dairymilk_i          (sel[3]),
    .biscuits_i           (sel[2]),
    .redbull_i            (sel[1]),
    .chocolated_i         (sel[0]),
    .money_i              (money),
    .cold_drink_o         (cold_drink_o),
    .dairymilk_o          (dairymilk_o),
    .biscuits_o           (biscuits_o),
    .redbull_o            (redbull_o),
    .chocolate_o          (chocolate_o),
    .insufficient_money_o (insufficient_money_o),
    .money_invalid_o      (money_invalid_o),
    .return_change_o      (return_change_o)
  );

  // ---------------- scoreboard ----------------
  // Output vector layout: {items[4:0], insufficient, invalid, change[8:0]}
  localparam int W = 16;
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] zero_out = '0;

  function automatic logic [W-1:0] observed();
    return {cold_drink_o, dairymilk_o, biscuits_o, redbull_o, chocolate_o,
            insufficient_money_o, money_invalid_o, return_change_o};
  endfunction

  // Reference model: price list lookup and plain arithmetic on the request.
  function automatic logic [W-1:0] model(input logic [4:0] s, input logic [8:0] m);
    int prices [5];
    int total;
    int mi;
    prices = '{25, 20, 10, 50, 30};   // cold drink, dairymilk, biscuits, redbull, chocolate
    total = 0;
    mi = int'(m);
    for (int i = 0; i < 5; i++)
      if (s[4-i]) total += prices[i];
    if (mi == 0 || (mi % 5) != 0 || mi > 500)
      return {5'b00000, 1'b0, 1'b1, m};
    if (mi < total)
      return {5'b00000, 1'b1, 1'b0, m};
    return {s, 1'b0, 1'b0, 9'(mi - total)};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare DUT outputs against the oldest queued expectation.
  task automatic check_next(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] s, input logic [8:0] m);
    @(negedge clk);
    sel   = s;
    money = m;
  endtask

  // Issue a request. If the machine is holding a previous result, the first
  // edge returns it to IDLE (zero gap) before the new capture.
  task automatic vend(input string tag, input logic [4:0] s, input logic [8:0] m,
                      input bit from_hold);
    drive(s, m);
    exp_q.push_back(model(s, m));
    if (from_hold) begin
      @(posedge clk); #1;
      check({tag, "_gap"}, observed(), zero_out);
    end
    @(posedge clk); #1;            // capture edge
    check({tag, "_eval"}, observed(), zero_out);
    @(posedge clk); #1;            // result edge
    check_next(tag);
  endtask

  // Keep the inputs steady and confirm the result does not change or repeat.
  task automatic hold_check(input string tag, input logic [4:0] s, input logic [8:0] m,
                            input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check(tag, observed(), model(s, m));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] prev_s;
  logic [8:0] prev_m;
  logic [4:0] rs;
  logic [8:0] rm;

  initial begin
    // Reset with active inputs
    sel = 5'b10010; money = 9'd100;
    repeat (3) @(posedge clk);
    #1 check("reset_active", observed(), zero_out);
    @(negedge clk);
    sel = 5'b00000; money = 9'd50;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_no_sel", observed(), zero_out);

    // Cold drink + redbull, 100 -> change 25, held with no repeat
    vend("cd_rb_100", 5'b10010, 9'd100, 1'b0);
    hold_check("cd_rb_hold", 5'b10010, 9'd100, 3);

    // Dairymilk + biscuits, 50 -> change 20
    vend("dm_bi_50", 5'b01100, 9'd50, 1'b1);
    // Three items, 100 -> change 40; then chocolate only -> change 70
    vend("dm_bi_ch_100", 5'b01101, 9'd100, 1'b1);
    vend("ch_100", 5'b00001, 9'd100, 1'b1);
    // Insufficient money
    vend("insuff_50", 5'b10010, 9'd50, 1'b1);
    hold_check("insuff_hold", 5'b10010, 9'd50, 2);
    // Invalid money (not a multiple of 5), then valid
    vend("invalid_107", 5'b10100, 9'd107, 1'b1);
    vend("cd_bi_50", 5'b10100, 9'd50, 1'b1);
    // Boundary amounts: exact price, 500 valid, 505 invalid, zero invalid
    vend("exact_135", 5'b11111, 9'd135, 1'b1);
    vend("max_500", 5'b00010, 9'd500, 1'b1);
    vend("over_505", 5'b00010, 9'd505, 1'b1);
    vend("zero_money", 5'b00100, 9'd0, 1'b1);

    // Input change during EVAL is ignored; HOLD then sees the mismatch
    drive(5'b01000, 9'd5);                 // leave HOLD
    @(posedge clk); #1;
    check("eval_gap", observed(), zero_out);
    drive(5'b00100, 9'd20);                // captured on next edge
    exp_q.push_back(model(5'b00100, 9'd20));
    @(posedge clk);
    @(negedge clk);
    sel = 5'b01000; money = 9'd40;         // change while in EVAL
    exp_q.push_back(model(5'b01000, 9'd40));
    @(posedge clk); #1;
    check_next("eval_ignore");
    @(posedge clk); #1;
    check("eval_restart_gap", observed(), zero_out);
    @(posedge clk); #1;
    check("eval_restart_cap", observed(), zero_out);
    @(posedge clk); #1;
    check_next("eval_restart_res");

    // Reset during HOLD clears outputs immediately
    vend("pre_reset", 5'b10000, 9'd30, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("reset_in_hold", observed(), zero_out);
    @(posedge clk); #1;
    check("reset_held", observed(), zero_out);
    @(negedge clk);
    sel = 5'b00000; money = 9'd0;
    rst = 1'b0;

    // Randomized requests, each different from the previous one
    prev_s = 5'b00000;
    prev_m = 9'd0;
    for (int n = 0; n < 40; n++) begin
      do begin
        rs = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 2) == 0)
          rm = 9'($urandom_range(0, 511));
        else
          rm = 9'($urandom_range(0, 102) * 5);
      end while ({rs, rm} == {prev_s, prev_m});
      vend("random", rs, rm, n != 0);
      if ($urandom_range(0, 3) == 0)
        hold_check("random_hold", rs, rm, 2);
      prev_s = rs;
      prev_m = rm;
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
